// File: rtl/sim_uart_rx_monitor_if.sv
// Byte stream from the UART receive monitor to its consumer (valid/ready, first-word-fall-through).
interface sim_uart_rx_monitor_if;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;

    modport master (
        output byte_o,
        output byte_valid_o,
        input  byte_ready_i
    );

    modport slave (
        input  byte_o,
        input  byte_valid_o,
        output byte_ready_i
    );
endinterface

// File: rtl/sim_uart_rx_monitor.sv
// 8N1 UART receive monitor: deserialises the CPU TX line, buffers bytes in a FIFO, counts newlines.
// Optional simulation console echo enabled by defining UART_MONITOR_PRINT_EN.
module sim_uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT    = 32'd10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         rxd_i,
    sim_uart_rx_monitor_if.master        byte_if,
    output logic                         framing_err_o,
    output logic                         overflow_o,
    output logic [15:0]                  line_count_o,
    output logic                         busy_o
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W   = FIFO_DEPTH_LOG2 + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         r_sync1;
    logic                         r_sync2;
    logic                         r_prev;
    logic [15:0]                  r_cnt;
    logic [15:0]                  w_cnt_nxt;
    logic [2:0]                   r_bit_idx;
    logic [2:0]                   w_bit_nxt;
    logic [7:0]                   r_shift;
    logic [7:0]                   w_shift_nxt;
    logic                         w_push;
    logic                         w_frame_err;
    logic                         w_fall;
    logic                         w_cnt_zero;

    logic [7:0]                   r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]             r_count;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_pop;
    logic                         w_push_ok;
    logic                         w_overflow;

    assign w_fall     = r_prev & ~r_sync2;
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state   <= IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync1   <= rxd_i;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        r_shift <= w_shift_nxt;
    end

    // Every timed state counts down to zero and samples the synchronised line there
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_M1;
                end
            end
            START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else if (!r_sync2) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = FULL_M1;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = FULL_M1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else if (r_sync2) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_frame_err = 1'b1;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy_o = (r_state != IDLE);

    // A push into a full FIFO is still accepted when the head is popped in the same cycle
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = !w_empty && byte_if.byte_ready_i;
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_overflow = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            framing_err_o <= 1'b0;
            overflow_o    <= 1'b0;
            line_count_o  <= 16'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            if (w_frame_err) begin
                framing_err_o <= 1'b1;
            end
            if (w_overflow) begin
                overflow_o <= 1'b1;
            end
            if (w_push_ok && (r_shift == 8'h0A)) begin
                line_count_o <= line_count_o + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i && w_push_ok) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign byte_if.byte_valid_o = !w_empty;
    assign byte_if.byte_o       = w_empty ? 8'h00 : r_mem[r_rd_ptr];

`ifdef UART_MONITOR_PRINT_EN
    always @(posedge clk_i) begin
        if (reset_i && w_push_ok) begin
            $write("%c", r_shift);
        end
        if (reset_i && w_frame_err) begin
            $display("%0t UART: framing error", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_uart_rx_monitor.sv
// Directed bench for sim_uart_rx_monitor at CLKS_PER_BIT=10, checked with immediate assertions.
module tb_sim_uart_rx_monitor;

    localparam int CPB = 10;

    logic        clk;
    logic        reset_i;
    logic        rxd_i;
    logic        framing_err_o;
    logic        overflow_o;
    logic [15:0] line_count_o;
    logic        busy_o;

    sim_uart_rx_monitor_if byte_if ();

    sim_uart_rx_monitor #(
        .CLKS_PER_BIT    (32'd10),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .rxd_i         (rxd_i),
        .byte_if       (byte_if.master),
        .framing_err_o (framing_err_o),
        .overflow_o    (overflow_o),
        .line_count_o  (line_count_o),
        .busy_o        (busy_o)
    );

    int n_vec;
    int n_err;
    int cyc;
    int first_valid_cyc;
    int valid_cycles;
    logic [7:0] rxq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every byte the consumer pops, plus when the first one appeared
    always @(negedge clk) begin
        if (byte_if.byte_valid_o === 1'b1) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (byte_if.byte_ready_i === 1'b1) rxq.push_back(byte_if.byte_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_i = b[i];
            tick(CPB);
        end
        rxd_i = stop_bit;
        tick(CPB);
        rxd_i = 1'b1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        rxd_i   = 1'b1;
        tick(3);
        reset_i = 1'b1;
        tick(1);
    endtask

    initial begin
        int t_start;
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        first_valid_cyc = -1;
        valid_cycles = 0;
        reset_i = 1'b0;
        rxd_i = 1'b1;
        byte_if.byte_ready_i = 1'b1;
        tick(4);
        @(negedge clk);
        check("rst_valid", 32'(byte_if.byte_valid_o), 32'd0);
        check("rst_byte",  32'(byte_if.byte_o), 32'h00);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_lines", 32'(line_count_o), 32'd0);
        check("rst_ferr",  32'(framing_err_o), 32'd0);
        check("rst_ovf",   32'(overflow_o), 32'd0);

        // Idle line
        @(posedge clk); #1;
        reset_i = 1'b1;
        tick(200);
        @(negedge clk);
        check("idle_valid", 32'(byte_if.byte_valid_o), 32'd0);
        check("idle_busy",  32'(busy_o), 32'd0);
        check("idle_flags", {30'd0, framing_err_o, overflow_o}, 32'd0);

        // Two back-to-back frames, consumer always ready
        @(posedge clk); #1;
        rxq.delete();
        first_valid_cyc = -1;
        valid_cycles = 0;
        t_start = cyc;
        send_byte(8'h41, 1'b1);
        send_byte(8'h0A, 1'b1);
        tick(30);
        @(negedge clk);
        check("b2b_latency_ok", 32'((first_valid_cyc - t_start >= 97) && (first_valid_cyc - t_start <= 99)), 32'd1);
        check("b2b_count",   32'(rxq.size()), 32'd2);
        check("b2b_byte0",   32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h41);
        check("b2b_byte1",   32'(rxq.size() > 1 ? rxq[1] : 8'hxx), 32'h0A);
        check("b2b_vcycles", 32'(valid_cycles), 32'd2);
        check("b2b_lines",   32'(line_count_o), 32'd1);
        check("b2b_flags",   {30'd0, framing_err_o, overflow_o}, 32'd0);

        // Three-cycle glitch is rejected in START
        @(posedge clk); #1;
        rxq.delete();
        rxd_i = 1'b0;
        tick(3);
        rxd_i = 1'b1;
        tick(1);
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        tick(CPB);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy_o), 32'd0);
        check("glitch_nopush",  32'(rxq.size()), 32'd0);
        check("glitch_valid",   32'(byte_if.byte_valid_o), 32'd0);
        check("glitch_ferr",    32'(framing_err_o), 32'd0);

        // Bad stop bit, then a good frame
        @(posedge clk); #1;
        send_byte(8'h55, 1'b0);
        tick(20);
        @(negedge clk);
        check("ferr_set",   32'(framing_err_o), 32'd1);
        check("ferr_busy",  32'(busy_o), 32'd0);
        check("ferr_none",  32'(rxq.size()), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h33, 1'b1);
        tick(20);
        @(negedge clk);
        check("ferr_next_cnt",  32'(rxq.size()), 32'd1);
        check("ferr_next_byte", 32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h33);
        check("ferr_sticky",    32'(framing_err_o), 32'd1);

        // Reset clears the sticky flags and line count
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("rst2_ferr",  32'(framing_err_o), 32'd0);
        check("rst2_lines", 32'(line_count_o), 32'd0);

        // Overflow: 17 bytes into a 16-entry FIFO with no consumer
        @(posedge clk); #1;
        byte_if.byte_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        tick(20);
        @(negedge clk);
        check("ovf_valid", 32'(byte_if.byte_valid_o), 32'd1);
        check("ovf_flag",  32'(overflow_o), 32'd1);
        check("ovf_head",  32'(byte_if.byte_o), 32'h00);
        check("ovf_lines", 32'(line_count_o), 32'd1);
        @(posedge clk); #1;
        rxq.delete();
        byte_if.byte_ready_i = 1'b1;
        tick(24);
        @(negedge clk);
        check("drain_count", 32'(rxq.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_byte%0d", i), 32'(i < rxq.size() ? rxq[i] : 8'hxx), 32'(i));
        end
        check("drain_empty", 32'(byte_if.byte_valid_o), 32'd0);

        // Reset in the middle of the data bits, then a clean frame
        @(posedge clk); #1;
        rxq.delete();
        rxd_i = 1'b0;
        tick(4 * CPB);
        reset_i = 1'b0;
        rxd_i = 1'b1;
        tick(3);
        reset_i = 1'b1;
        tick(20);
        @(negedge clk);
        check("mid_busy",  32'(busy_o), 32'd0);
        check("mid_valid", 32'(byte_if.byte_valid_o), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h7E, 1'b1);
        tick(20);
        @(negedge clk);
        check("mid_count", 32'(rxq.size()), 32'd1);
        check("mid_byte",  32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h7E);
        check("mid_ferr",  32'(framing_err_o), 32'd0);
        check("mid_ovf",   32'(overflow_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sim_uart_rx_monitor.md
Name: sim_uart_rx_monitor

Overview:
- Sits downstream of the CPU UART transmit pin (ftdi_txd) in the pipelined simulation top.
- Deserialises 8N1 serial frames into bytes and checks framing.
- Buffers received bytes in a small FIFO drained by a valid/ready consumer, and counts completed text lines.
- Lets the bench check console output from software; synthesisable apart from the optional print feature.

Parameters:
- CLKS_PER_BIT, 32'd10, clk_i cycles per UART bit; legal range 4..65535.
- FIFO_DEPTH_LOG2, 4, FIFO depth is 2**FIFO_DEPTH_LOG2 entries (default 16).

Ports:
- clk_i  input  1  system clock, same clock as the CPU core.
- reset_i  input  1  synchronous reset, active-low.
- rxd_i  input  1  serial line from CPU TX; idle high.
- byte_o  output  8  FIFO head byte.
- byte_valid_o  output  1  FIFO not empty.
- byte_ready_i  input  1  consumer pops the head when byte_valid_o && byte_ready_i at a rising edge.
- framing_err_o  output  1  sticky: a stop bit was sampled low.
- overflow_o  output  1  sticky: a byte arrived while the FIFO was full.
- line_count_o  output  16  number of 8'h0A bytes received; wraps at 16'hFFFF to 0.
- busy_o  output  1  high while a frame is being received.

Behaviour:
- Reset (reset_i low at a rising clk_i edge):
  - State = IDLE; FIFO pointers and count cleared.
  - byte_valid_o=0, byte_o=8'h00, framing_err_o=0, overflow_o=0, line_count_o=0, busy_o=0.
  - A frame in progress is abandoned; the receiver resumes hunting for a start bit after reset is released.
- Input synchroniser: rxd_i passes through a 2-flop synchroniser whose flops reset to 1. All sampling uses the synchronised value, adding 2 cycles of latency.
- State machine:
  - IDLE: on a synchronised 1->0 transition, load the bit counter with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: at counter 0, sample the line.
    - Low: reload the counter with CLKS_PER_BIT-1 and go to DATA with bit index 0.
    - High: glitch; return to IDLE with no other effect.
  - DATA: at each counter 0, shift the sample into the shift register LSB-first and reload. After bit index 7 go to STOP.
  - STOP: at counter 0, sample the line.
    - High: push the byte.
    - Low: set framing_err_o, discard the byte, go to WAIT_IDLE.
    - A good stop goes directly to IDLE.
  - WAIT_IDLE: stay until the synchronised line is high, then go to IDLE. This prevents a break condition from producing false starts.
- busy_o = 1 in START, DATA, STOP and WAIT_IDLE.
- Push timing: the byte enters the FIFO on the stop-bit sample edge. byte_valid_o rises on the next cycle.
- Total latency: from the start-bit falling edge on rxd_i to byte_valid_o is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, within ±1 cycle.
- FIFO:
  - Registered head; first-word-fall-through; byte_o is valid whenever byte_valid_o is high.
  - Push and pop in the same cycle while non-empty: both occur and the count is unchanged.
  - Push while full and no pop in that cycle: the byte is dropped and overflow_o is set.
  - Push while full with a pop in that cycle: the push is accepted.
  - Pop while empty is ignored.
  - Read and write pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. Full/empty are decided by a count register of FIFO_DEPTH_LOG2+1 bits.
- line_count_o increments when a byte equal to 8'h0A is accepted into the FIFO. Dropped (overflow) and framing-error bytes do not count.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: UART_MONITOR_PRINT_EN.
- Defined:
  - Each accepted byte is also emitted with $write("%c") in the same cycle it is pushed.
  - On framing error, prints "$time UART: framing error" via $display.
  - The print code is simulation-only, guarded by the macro.
- Undefined: no system tasks in the module; behaviour is otherwise identical and the module is synthesisable.

Test Plan:
- Reset, then idle line held high for 200 cycles (CLKS_PER_BIT=10) -> byte_valid_o=0, busy_o=0, line_count_o=0, all flags 0.
- Send 8'h41, then 8'h0A, back-to-back, with byte_ready_i=1 -> byte_o reads 8'h41 then 8'h0A, each valid for 1 cycle; line_count_o=1; flags 0; latency within spec ±1.
- Hold rxd_i low for 3 cycles, then high -> START rejects the glitch; no byte pushed; busy_o returns to 0 within CLKS_PER_BIT cycles.
- Send 8'h55 with the stop bit forced low, then the line high, then a valid 8'h33 -> framing_err_o=1, only 8'h33 appears in the FIFO.
- byte_ready_i=0, send 17 bytes 8'h00..8'h10 -> byte_valid_o=1, overflow_o=1; draining yields 8'h00..8'h0F, 16 bytes, in order; 8'h10 is lost; line_count_o=1 (8'h0A).
- Assert reset_i low in the middle of the DATA bits of a frame, release, then send 8'h7E -> only 8'h7E is received; no framing error.
